sudoku_board_io: RTL and testbench
==================================

Name: sudoku_board_io

Overview:
- Host-side initiator for the sudoku board memory, the 81-entry store of 4-bit cell values plus row, column and box "digit used" marks.
- Load path: clears every mark, accepts 81 puzzle cells over a valid/ready stream, then writes each value and sets its three marks.
- Dump path: after the solver finishes, reads the board back and streams the 81 values out over valid/ready.
- Sits between the top-level host interface and the memory port mux. `o_mem_own` selects this block's drive of the memory ports.

Parameters:
- `N_SIDE`, 9, board side length; cell count is N_SIDE*N_SIDE = 81.
- `DW`, 4, cell value width.
- `AW`, 7, memory address width.

Ports:
- `clk` input 1: clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `i_load_start` input 1: pulse, begin a clear+load; honoured only in IDLE.
- `i_dump_start` input 1: pulse, begin a dump; honoured only in IDLE.
- `i_cell_valid` input 1: load stream valid.
- `i_cell_data` input DW: load stream cell value; 0 = empty, 1-9 = given.
- `o_cell_ready` output 1: load stream ready.
- `o_out_valid` output 1: dump stream valid.
- `o_out_data` output DW: dump stream cell value.
- `i_out_ready` input 1: dump stream ready.
- `o_mem_own` output 1: this block drives the memory ports.
- `o_we` output 1: memory data write enable.
- `o_we_mark` output 1: memory mark write enable (row, col and box together).
- `o_wrdata` output DW: memory write data.
- `o_wrdata_mark` output 1: mark value, driven identically to all three mark write-data ports.
- `o_addr` output AW: cell address.
- `o_addr_mark_row` output AW: row mark address.
- `o_addr_mark_col` output AW: column mark address.
- `o_addr_mark_matrix` output AW: box mark address.
- `i_rddata` input DW: memory read data; valid 1 cycle after the address is presented with `o_we`=0.
- `o_load_done` output 1: 1-cycle pulse at end of load.
- `o_dump_done` output 1: 1-cycle pulse at end of dump.
- `o_load_err` output 1: sticky; set on any value > 9; cleared by `i_load_start`.
- `o_busy` output 1: high in any state other than IDLE.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; counters 0. Reset asserted mid-operation aborts immediately; no partial state is retained.
- FSM states: IDLE, CLEAR, LOAD, LDONE, RD_ISSUE, RD_WAIT, OUT, DDONE.
- IDLE:
  - `i_load_start` goes to CLEAR and clears `o_load_err`.
  - Else `i_dump_start` goes to RD_ISSUE.
  - If both are high in the same cycle, load wins.
  - Either start pulse outside IDLE is ignored.
- Indexing: cell index k = 0..80 with row r, column c, box b = (r/3)*3 + c/3.
  - k, r, c and b are maintained as incrementing counters; no divider.
  - c wraps 8→0 and increments r.
  - The mark address for unit u (row/col/box) and digit d is u*9 + (d-1).
- CLEAR: 81 cycles.
  - `o_we_mark`=1, `o_wrdata_mark`=0.
  - All three mark addresses = k.
  - `o_we`=0.
  - After k = 80, go to LOAD with k, r, c, b reset to 0.
- LOAD:
  - `o_cell_ready`=1. A cell is accepted on `i_cell_valid` && `o_cell_ready`.
  - Write happens in the same cycle as the handshake:
    - `o_we`=1, `o_addr`=k, `o_wrdata`=value.
    - If value is 1-9: `o_we_mark`=1, `o_wrdata_mark`=1, row addr = r*9+d-1, col addr = c*9+d-1, box addr = b*9+d-1.
  - Value 0: `o_we_mark`=0.
  - Value 10-15: set `o_load_err`; write 0; no mark write.
  - The load is throughput 1 cell/cycle. Duplicate givens are not checked.
  - After accepting k = 80, go to LDONE.
- LDONE: 1 cycle; `o_load_done`=1; go to IDLE.
- Dump path:
  - RD_ISSUE: `o_addr`=k, `o_we`=0; go to RD_WAIT.
  - RD_WAIT: capture `i_rddata` into the output register; go to OUT.
  - OUT: `o_out_valid`=1 with data held stable until `i_out_ready`.
    - On the handshake, if k = 80 go to DDONE; else k++ and go to RD_ISSUE.
  - Dump throughput is 1 cell per 3 cycles at full ready. `o_out_data` must not change while valid and not ready.
- DDONE: 1 cycle; `o_dump_done`=1; go to IDLE.
- `o_mem_own`=1 in CLEAR, LOAD, RD_ISSUE, RD_WAIT and OUT.
- Memory write enables and `o_cell_ready` are 0 in every other state.

Decomposition:
- Shared package `sudoku_pkg`: N_SIDE=9, N_CELLS=81, DW=4, AW=7, the FSM state enum, and a `mark_addr(unit, digit)` function.
- One sub-module, `sudoku_cell_counter`:
  - Holds k, r, c and b.
  - Inputs: clear, advance.
  - Output: `o_last` when k = 80.

Test Plan:
- Reset, then `i_load_start`: 81 CLEAR cycles with `o_we_mark`=1, mark data 0, mark addresses 0..80, then `o_cell_ready`=1.
- Load k=0 value 5: row, col and box mark addresses all 4. Load k=5 value 7 (r0, c5, b1): row 6, col 51, box 15.
- Load k=10 value 3 (r1, c1, b0): row 11, col 11, box 2. Load k=80 value 9: all 80. Then `o_load_done` pulses one cycle after the k=80 handshake.
- Load with stalling valid and a value-0 cell: no write while valid is low; value 0 gives `o_we`=1 and `o_we_mark`=0. A value of 12 sets sticky `o_load_err` and writes 0.
- Dump of a known memory model with `i_out_ready` toggling 1/0: 81 beats in index order, data stable under stall; `o_dump_done` pulses once.
- Assert `rst_n`=0 at cell 40 of a load: all outputs 0 asynchronously. `i_dump_start` during a load is ignored. Simultaneous start pulses in IDLE select load.

Source files
------------

// File: rtl/sudoku_pkg.sv
// Shared constants, FSM state encoding and mark addressing for the sudoku board host port.
package sudoku_pkg;

  localparam int N_SIDE   = 9;
  localparam int N_CELLS  = N_SIDE * N_SIDE;
  localparam int BOX_SIDE = 3;
  localparam int DW       = 4;
  localparam int AW       = 7;
  localparam int UW       = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_LOAD,
    ST_LDONE,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_OUT,
    ST_DDONE
  } state_e;

  // Mark slot for unit u (row, column or box) and digit d in 1..9.
  function automatic logic [AW-1:0] mark_addr(input logic [UW-1:0] unit,
                                              input logic [DW-1:0] digit);
    return AW'(unit) * AW'(N_SIDE) + AW'(digit) - AW'(1);
  endfunction

endpackage

// File: rtl/sudoku_board_io_cell_counter.sv
// Cell index walker: linear index k plus row, column and box, all kept as counters.
module sudoku_cell_counter
  import sudoku_pkg::*;
#(
  parameter int SIDE = N_SIDE
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clear,
  input  logic          i_advance,
  output logic [AW-1:0] o_k,
  output logic [UW-1:0] o_r,
  output logic [UW-1:0] o_c,
  output logic [UW-1:0] o_b,
  output logic          o_last
);

  localparam logic [AW-1:0] K_LAST   = AW'(SIDE * SIDE - 1);
  localparam logic [UW-1:0] C_LAST   = UW'(SIDE - 1);
  localparam logic [1:0]    SUB_LAST = 2'(BOX_SIDE - 1);
  localparam logic [UW-1:0] B_BACK   = UW'(BOX_SIDE - 1);

  logic [AW-1:0] k_q, k_d;
  logic [UW-1:0] r_q, r_d, c_q, c_d, b_q, b_d;
  logic [1:0]    cb_q, cb_d, rb_q, rb_d;

  // cb/rb track position inside the current box so b can step without a divider.
  always_comb begin
    k_d  = k_q;
    r_d  = r_q;
    c_d  = c_q;
    b_d  = b_q;
    cb_d = cb_q;
    rb_d = rb_q;
    if (i_clear) begin
      k_d  = '0;
      r_d  = '0;
      c_d  = '0;
      b_d  = '0;
      cb_d = '0;
      rb_d = '0;
    end else if (i_advance) begin
      k_d = k_q + AW'(1);
      if (c_q == C_LAST) begin
        c_d  = '0;
        cb_d = '0;
        r_d  = r_q + UW'(1);
        if (rb_q == SUB_LAST) begin
          rb_d = '0;
          b_d  = b_q + UW'(1);
        end else begin
          rb_d = rb_q + 2'd1;
          b_d  = b_q - B_BACK;
        end
      end else begin
        c_d = c_q + UW'(1);
        if (cb_q == SUB_LAST) begin
          cb_d = '0;
          b_d  = b_q + UW'(1);
        end else begin
          cb_d = cb_q + 2'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q  <= '0;
      r_q  <= '0;
      c_q  <= '0;
      b_q  <= '0;
      cb_q <= '0;
      rb_q <= '0;
    end else begin
      k_q  <= k_d;
      r_q  <= r_d;
      c_q  <= c_d;
      b_q  <= b_d;
      cb_q <= cb_d;
      rb_q <= rb_d;
    end
  end

  assign o_k    = k_q;
  assign o_r    = r_q;
  assign o_c    = c_q;
  assign o_b    = b_q;
  assign o_last = (k_q == K_LAST);

endmodule

// File: rtl/sudoku_board_io.sv
// Host-side initiator for the sudoku board memory: clear+load from a stream, dump back out.
//   state    | meaning
//   IDLE     | waiting for a load or dump start
//   CLEAR    | zeroing mark slot k, one per cycle
//   LOAD     | accepting cell k, writing value and its three marks
//   LDONE    | load finished pulse
//   RD_ISSUE | presenting read address k
//   RD_WAIT  | capturing read data
//   OUT      | offering cell k on the dump stream
//   DDONE    | dump finished pulse
module sudoku_board_io #(
  parameter int N_SIDE = 9,
  parameter int DW     = 4,
  parameter int AW     = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_load_start,
  input  logic          i_dump_start,
  input  logic          i_cell_valid,
  input  logic [DW-1:0] i_cell_data,
  output logic          o_cell_ready,
  output logic          o_out_valid,
  output logic [DW-1:0] o_out_data,
  input  logic          i_out_ready,
  output logic          o_mem_own,
  output logic          o_we,
  output logic          o_we_mark,
  output logic [DW-1:0] o_wrdata,
  output logic          o_wrdata_mark,
  output logic [AW-1:0] o_addr,
  output logic [AW-1:0] o_addr_mark_row,
  output logic [AW-1:0] o_addr_mark_col,
  output logic [AW-1:0] o_addr_mark_matrix,
  input  logic [DW-1:0] i_rddata,
  output logic          o_load_done,
  output logic          o_dump_done,
  output logic          o_load_err,
  output logic          o_busy
);
  import sudoku_pkg::*;

  state_e        state_q, state_d;
  logic          err_q, err_d;
  logic [DW-1:0] out_data_q, out_data_d;

  logic                    cnt_clear, cnt_adv, cnt_last;
  logic [sudoku_pkg::AW-1:0] cnt_k;
  logic [UW-1:0]           cnt_r, cnt_c, cnt_b;
  logic                    cell_digit, cell_bad;

  sudoku_cell_counter #(.SIDE(N_SIDE)) u_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (cnt_clear),
    .i_advance (cnt_adv),
    .o_k       (cnt_k),
    .o_r       (cnt_r),
    .o_c       (cnt_c),
    .o_b       (cnt_b),
    .o_last    (cnt_last)
  );

  assign cell_digit = (i_cell_data != '0) && (i_cell_data <= DW'(N_SIDE));
  assign cell_bad   = (i_cell_data > DW'(N_SIDE));

  always_comb begin
    state_d            = state_q;
    err_d              = err_q;
    out_data_d         = out_data_q;
    cnt_clear          = 1'b0;
    cnt_adv            = 1'b0;
    o_cell_ready       = 1'b0;
    o_out_valid        = 1'b0;
    o_mem_own          = 1'b0;
    o_we               = 1'b0;
    o_we_mark          = 1'b0;
    o_wrdata           = '0;
    o_wrdata_mark      = 1'b0;
    o_addr             = '0;
    o_addr_mark_row    = '0;
    o_addr_mark_col    = '0;
    o_addr_mark_matrix = '0;
    o_load_done        = 1'b0;
    o_dump_done        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_clear = 1'b1;
        if (i_load_start) begin
          state_d = ST_CLEAR;
          err_d   = 1'b0;
        end else if (i_dump_start) begin
          state_d = ST_RD_ISSUE;
        end
      end

      ST_CLEAR: begin
        o_mem_own          = 1'b1;
        o_addr             = AW'(cnt_k);
        o_we_mark          = 1'b1;
        o_addr_mark_row    = AW'(cnt_k);
        o_addr_mark_col    = AW'(cnt_k);
        o_addr_mark_matrix = AW'(cnt_k);
        cnt_adv            = 1'b1;
        if (cnt_last) begin
          cnt_clear = 1'b1;
          state_d   = ST_LOAD;
        end
      end

      ST_LOAD: begin
        o_mem_own    = 1'b1;
        o_cell_ready = 1'b1;
        o_addr       = AW'(cnt_k);
        if (i_cell_valid) begin
          o_we    = 1'b1;
          cnt_adv = 1'b1;
          // Out-of-range values are stored as empty so the solver never sees them.
          if (cell_digit) begin
            o_wrdata           = i_cell_data;
            o_we_mark          = 1'b1;
            o_wrdata_mark      = 1'b1;
            o_addr_mark_row    = AW'(mark_addr(cnt_r, i_cell_data));
            o_addr_mark_col    = AW'(mark_addr(cnt_c, i_cell_data));
            o_addr_mark_matrix = AW'(mark_addr(cnt_b, i_cell_data));
          end else if (cell_bad) begin
            err_d = 1'b1;
          end
          if (cnt_last) begin
            state_d = ST_LDONE;
          end
        end
      end

      ST_LDONE: begin
        o_load_done = 1'b1;
        state_d     = ST_IDLE;
      end

      ST_RD_ISSUE: begin
        o_mem_own = 1'b1;
        o_addr    = AW'(cnt_k);
        state_d   = ST_RD_WAIT;
      end

      ST_RD_WAIT: begin
        o_mem_own  = 1'b1;
        o_addr     = AW'(cnt_k);
        out_data_d = i_rddata;
        state_d    = ST_OUT;
      end

      ST_OUT: begin
        o_mem_own   = 1'b1;
        o_addr      = AW'(cnt_k);
        o_out_valid = 1'b1;
        if (i_out_ready) begin
          if (cnt_last) begin
            state_d = ST_DDONE;
          end else begin
            cnt_adv = 1'b1;
            state_d = ST_RD_ISSUE;
          end
        end
      end

      ST_DDONE: begin
        o_dump_done = 1'b1;
        state_d     = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      err_q      <= 1'b0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      err_q      <= err_d;
      out_data_q <= out_data_d;
    end
  end

  assign o_out_data = out_data_q;
  assign o_load_err = err_q;
  assign o_busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sudoku_board_io.sv
// Randomized bench for sudoku_board_io against a behavioural board and mark model.
module tb_sudoku_board_io;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_load_start, i_dump_start, i_cell_valid, i_out_ready;
  logic [3:0] i_cell_data, i_rddata;
  logic       o_cell_ready, o_out_valid, o_mem_own, o_we, o_we_mark, o_wrdata_mark;
  logic [3:0] o_out_data, o_wrdata;
  logic [6:0] o_addr, o_addr_mark_row, o_addr_mark_col, o_addr_mark_matrix;
  logic       o_load_done, o_dump_done, o_load_err, o_busy;

  sudoku_board_io dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .i_load_start       (i_load_start),
    .i_dump_start       (i_dump_start),
    .i_cell_valid       (i_cell_valid),
    .i_cell_data        (i_cell_data),
    .o_cell_ready       (o_cell_ready),
    .o_out_valid        (o_out_valid),
    .o_out_data         (o_out_data),
    .i_out_ready        (i_out_ready),
    .o_mem_own          (o_mem_own),
    .o_we               (o_we),
    .o_we_mark          (o_we_mark),
    .o_wrdata           (o_wrdata),
    .o_wrdata_mark      (o_wrdata_mark),
    .o_addr             (o_addr),
    .o_addr_mark_row    (o_addr_mark_row),
    .o_addr_mark_col    (o_addr_mark_col),
    .o_addr_mark_matrix (o_addr_mark_matrix),
    .i_rddata           (i_rddata),
    .o_load_done        (o_load_done),
    .o_dump_done        (o_dump_done),
    .o_load_err         (o_load_err),
    .o_busy             (o_busy)
  );

  always #5 clk = ~clk;

  logic [45:0] all_outs;
  assign all_outs = {o_cell_ready, o_out_valid, o_out_data, o_mem_own, o_we, o_we_mark,
                     o_wrdata, o_wrdata_mark, o_addr, o_addr_mark_row, o_addr_mark_col,
                     o_addr_mark_matrix, o_load_done, o_dump_done, o_load_err, o_busy};

  // Board memory model; marks preset to 1 under reset so the clear pass is observable.
  logic [3:0]   mem [0:127];
  logic [127:0] row_m, col_m, box_m;
  always @(posedge clk) begin
    if (!rst_n) begin
      row_m <= '1;
      col_m <= '1;
      box_m <= '1;
    end else if (o_mem_own && o_we_mark) begin
      row_m[o_addr_mark_row]    <= o_wrdata_mark;
      col_m[o_addr_mark_col]    <= o_wrdata_mark;
      box_m[o_addr_mark_matrix] <= o_wrdata_mark;
    end
    if (o_mem_own && o_we) mem[o_addr] <= o_wrdata;
    i_rddata <= mem[o_addr];
  end

  int done_cnt = 0;
  always @(negedge clk) if (o_dump_done) done_cnt++;

  int n_checks = 0;
  int n_pass   = 0;
  int cells [0:80];
  logic [127:0] row_ref, col_ref, box_ref;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int ev(input int k);
    return (cells[k] > 9) ? 0 : cells[k];
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic run_clear(input bit both_starts);
    i_load_start = 1'b1;
    i_dump_start = both_starts;
    #1;
    check_eq("start_idle", o_busy, 1'b0);
    step();
    i_load_start = 1'b0;
    i_dump_start = 1'b0;
    check_eq("err_cleared", o_load_err, 1'b0);
    for (int i = 0; i < 81; i++) begin
      if (i > 0) step();
      check_eq($sformatf("clear_%0d", i),
               {o_mem_own, o_we_mark, o_wrdata_mark, o_we, o_cell_ready,
                o_addr_mark_row, o_addr_mark_col, o_addr_mark_matrix},
               {5'b11000, 7'(i), 7'(i), 7'(i)});
    end
    step();
    check_eq("load_ready", o_cell_ready, 1'b1);
  endtask

  task automatic load_cells(input int n, input bit inject_dump);
    for (int k = 0; k < n; k++) begin
      int stalls, r, c, b, v;
      stalls = ($urandom_range(0, 3) == 0) ? 1 : 0;
      if (k == 3 || k == 7) stalls = 2;
      for (int s = 0; s < stalls; s++) begin
        i_cell_valid = 1'b0;
        i_cell_data  = 4'($urandom_range(0, 15));
        if (inject_dump && k == 7 && s == 0) i_dump_start = 1'b1;
        #1;
        check_eq("stall_no_write", {o_cell_ready, o_we, o_we_mark}, 3'b100);
        step();
        i_dump_start = 1'b0;
      end
      v = cells[k];
      r = k / 9;
      c = k % 9;
      b = (r / 3) * 3 + c / 3;
      i_cell_valid = 1'b1;
      i_cell_data  = 4'(v);
      #1;
      check_eq($sformatf("ld_data_%0d", k), {o_we, o_addr, o_wrdata}, {1'b1, 7'(k), 4'(ev(k))});
      check_eq("err_sticky", o_load_err, k > 30);
      if (v >= 1 && v <= 9)
        check_eq($sformatf("ld_mark_%0d", k),
                 {o_we_mark, o_wrdata_mark, o_addr_mark_row, o_addr_mark_col, o_addr_mark_matrix},
                 {2'b11, 7'(r * 9 + v - 1), 7'(c * 9 + v - 1), 7'(b * 9 + v - 1)});
      else
        check_eq($sformatf("ld_nomark_%0d", k), o_we_mark, 1'b0);
      if (k < n - 1) begin
        step();
        i_cell_valid = 1'b0;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    i_load_start = 1'b0;
    i_dump_start = 1'b0;
    i_cell_valid = 1'b0;
    i_cell_data  = '0;
    i_out_ready  = 1'b0;

    for (int k = 0; k < 81; k++) cells[k] = int'($urandom_range(0, 9));
    cells[0] = 5; cells[5] = 7; cells[10] = 3; cells[20] = 0; cells[30] = 12; cells[80] = 9;
    row_ref = '0; col_ref = '0; box_ref = '0;
    for (int k = 0; k < 81; k++) begin
      int r, c, b, v;
      v = cells[k]; r = k / 9; c = k % 9; b = (r / 3) * 3 + c / 3;
      if (v >= 1 && v <= 9) begin
        row_ref[r * 9 + v - 1] = 1'b1;
        col_ref[c * 9 + v - 1] = 1'b1;
        box_ref[b * 9 + v - 1] = 1'b1;
      end
    end

    repeat (3) step();
    check_eq("rst_outs", all_outs, '0);
    rst_n = 1'b1;
    step();
    check_eq("idle_busy", o_busy, 1'b0);

    // Full load with stalls and a dump request that must be ignored.
    run_clear(1'b0);
    load_cells(81, 1'b1);
    step();
    i_cell_valid = 1'b0;
    check_eq("load_done", {o_load_done, o_cell_ready, o_load_err}, 3'b101);
    step();
    check_eq("load_done_end", {o_load_done, o_busy}, 2'b00);
    check_eq("row_marks", row_m[80:0], row_ref[80:0]);
    check_eq("col_marks", col_m[80:0], col_ref[80:0]);
    check_eq("box_marks", box_m[80:0], box_ref[80:0]);
    step();
    check_eq("dump_ignored", o_busy, 1'b0);

    // Dump with ready stalled on every other beat.
    i_dump_start = 1'b1;
    step();
    i_dump_start = 1'b0;
    for (int k = 0; k < 81; k++) begin
      int w;
      w = 0;
      while (!o_out_valid && w < 8) begin
        step();
        w++;
      end
      check_eq($sformatf("dump_latency_%0d", k), w, 2);
      if (k % 2 == 1) begin
        i_out_ready = 1'b0;
        step();
        check_eq($sformatf("dump_hold_%0d", k), {o_out_valid, o_out_data}, {1'b1, 4'(ev(k))});
      end
      i_out_ready = 1'b1;
      #1;
      check_eq($sformatf("dump_beat_%0d", k), {o_out_valid, o_out_data}, {1'b1, 4'(ev(k))});
      step();
      i_out_ready = 1'b0;
    end
    check_eq("dump_done", {o_dump_done, o_mem_own}, 2'b10);
    step();
    check_eq("dump_done_end", {o_dump_done, o_busy}, 2'b00);
    check_eq("dump_done_count", done_cnt, 1);

    // Both starts together select load; then reset mid-load at cell 40.
    run_clear(1'b1);
    load_cells(40, 1'b0);
    step();
    i_cell_valid = 1'b1;
    i_cell_data  = 4'(cells[40]);
    #1;
    check_eq("pre_rst_write", {o_we, o_addr}, {1'b1, 7'd40});
    rst_n = 1'b0;
    #1;
    check_eq("async_rst", all_outs, '0);
    step();
    i_cell_valid = 1'b0;
    rst_n = 1'b1;
    step();
    check_eq("post_rst_idle", all_outs, '0);

    // A dump after reset must start from cell 0.
    i_dump_start = 1'b1;
    step();
    i_dump_start = 1'b0;
    check_eq("post_rst_addr", {o_mem_own, o_addr}, {1'b1, 7'd0});
    step();
    step();
    check_eq("post_rst_dump0", {o_out_valid, o_out_data}, {1'b1, 4'(ev(0))});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
